// File: rtl/seven_segment_monitor_if.sv
// Signal bundle between a seven-segment display source and its monitor.
// Handshake: none -- segments_in is a free-running level bus; digit_strobe is a one-cycle event flag.
interface seven_segment_monitor_if #(
    parameter int PERIOD_WIDTH = 24
);
    logic [6:0]              segments_in;
    logic                    clear_errors;
    logic [3:0]              digit;
    logic                    digit_valid;
    logic                    digit_strobe;
    logic [PERIOD_WIDTH-1:0] period;
    logic                    period_valid;
    logic                    seq_error;
    logic                    invalid_error;

    modport master (
        output segments_in, clear_errors,
        input  digit, digit_valid, digit_strobe, period, period_valid,
               seq_error, invalid_error
    );

    modport slave (
        input  segments_in, clear_errors,
        output digit, digit_valid, digit_strobe, period, period_valid,
               seq_error, invalid_error
    );
endinterface

// File: rtl/seven_segment_monitor.sv
// Glitch-filtering decoder for a seven-segment digit bus: recovers BCD digits,
// measures the cycle period between digit changes and flags illegal/out-of-order digits.
module seven_segment_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_WIDTH  = 24
) (
    input logic                   clk,
    input logic                   reset,
    seven_segment_monitor_if.slave mon
);
    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        PAT_BLANK   = 2'd0,
        PAT_DIGIT   = 2'd1,
        PAT_INVALID = 2'd2
    } pat_kind_e;

    logic [6:0]              seg_q;
    logic [6:0]              cand_q;
    logic [6:0]              acc_q;
    logic [7:0]              cnt_q;
    logic                    have_prev_q;
    logic [PERIOD_WIDTH-1:0] period_cnt_q;
    logic [3:0]              digit_q;
    logic                    digit_valid_q;
    logic                    strobe_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic                    period_valid_q;
    logic                    seq_q;
    logic                    inv_q;

    logic [6:0]              cand_d;
    logic [7:0]              cnt_d;
    logic                    accept;
    pat_kind_e               kind;
    logic [3:0]              dec_digit;
    logic                    accept_digit;
    logic                    accept_other;
    logic                    accept_invalid;
    logic [3:0]              exp_next;
    logic                    seq_hit;
    logic [PERIOD_WIDTH-1:0] period_inc;

    function automatic logic [5:0] decode(input logic [6:0] p);
        // Returns {kind, digit}
        logic [5:0] r;
        r = {PAT_INVALID, 4'd0};
        case (p)
            7'b0111111: r = {PAT_DIGIT, 4'd0};
            7'b0000110: r = {PAT_DIGIT, 4'd1};
            7'b1011011: r = {PAT_DIGIT, 4'd2};
            7'b1001111: r = {PAT_DIGIT, 4'd3};
            7'b1100110: r = {PAT_DIGIT, 4'd4};
            7'b1101101: r = {PAT_DIGIT, 4'd5};
            7'b1111100: r = {PAT_DIGIT, 4'd6};
            7'b0000111: r = {PAT_DIGIT, 4'd7};
            7'b1111111: r = {PAT_DIGIT, 4'd8};
            7'b1100111: r = {PAT_DIGIT, 4'd9};
            7'b0000000: r = {PAT_BLANK, 4'd0};
            default:    r = {PAT_INVALID, 4'd0};
        endcase
        return r;
    endfunction

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (seg_q != cand_q) begin
            cand_d = seg_q;
            cnt_d  = 8'd1;
        end else if (cnt_q < STABLE) begin
            cnt_d = cnt_q + 8'd1;
        end
        // Re-settling on the pattern already shown is not a new event.
        accept = (cnt_d == STABLE) && (cand_d != acc_q);
    end

    always_comb begin
        logic [5:0] dec;
        dec            = decode(cand_d);
        kind           = pat_kind_e'(dec[5:4]);
        dec_digit      = dec[3:0];
        accept_digit   = accept && (kind == PAT_DIGIT);
        accept_other   = accept && (kind != PAT_DIGIT);
        accept_invalid = accept && (kind == PAT_INVALID);
        exp_next       = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        seq_hit        = accept_digit && have_prev_q && (dec_digit != exp_next);
        period_inc     = (period_cnt_q == '1) ? period_cnt_q
                                              : period_cnt_q + PERIOD_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q          <= '0;
            cand_q         <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
            have_prev_q    <= 1'b0;
            period_cnt_q   <= '0;
            digit_q        <= '0;
            digit_valid_q  <= 1'b0;
            strobe_q       <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            seq_q          <= 1'b0;
            inv_q          <= 1'b0;
        end else begin
            seg_q        <= mon.segments_in;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            strobe_q     <= accept_digit;
            period_cnt_q <= accept_digit ? '0 : period_inc;
            if (accept) begin
                acc_q <= cand_d;
            end
            if (accept_digit) begin
                digit_q       <= dec_digit;
                digit_valid_q <= 1'b1;
                have_prev_q   <= 1'b1;
                if (have_prev_q) begin
                    period_q       <= period_inc;
                    period_valid_q <= 1'b1;
                end
            end else if (accept_other) begin
                // Blank or garbage breaks the sequence; the next digit starts fresh.
                digit_valid_q <= 1'b0;
                have_prev_q   <= 1'b0;
            end
            // A new error in the clearing cycle takes precedence over the clear.
            seq_q <= seq_hit        | (seq_q & ~mon.clear_errors);
            inv_q <= accept_invalid | (inv_q & ~mon.clear_errors);
        end
    end

    assign mon.digit         = digit_q;
    assign mon.digit_valid   = digit_valid_q;
    assign mon.digit_strobe  = strobe_q;
    assign mon.period        = period_q;
    assign mon.period_valid  = period_valid_q;
    assign mon.seq_error     = seq_q;
    assign mon.invalid_error = inv_q;
endmodule
